uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART constants: oversampling factor and default frame shape.
// Also imported by the transmitter and the top-level baud generator instantiation.
package uart_rx_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  // Counter width for an index over n items, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// 1-bit two-flop synchronizer with a configurable reset value; 2-cycle latency.
// No flow control: the output follows the input two clocks later.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver; done pulse one clock after the mid-stop-bit sample.
// No backpressure: each frame overwrites o_dout/o_frame_err when it completes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic            o_rx_done_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_frame_err,
  output logic            o_busy
);

  localparam int NW = cnt_width(DBIT);
  // The stop period may exceed one oversampling window, which needs a wider counter.
  localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   s, s_nx;
  logic [NW-1:0]   n, n_nx;
  logic [DBIT-1:0] b, b_nx;
  logic            rx_s;
  logic            done_nx;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (i_clk),
    .reset (i_reset),
    .d     (i_rx),
    .q     (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      s              <= '0;
      n              <= '0;
      b              <= '0;
      o_rx_done_tick <= 1'b0;
      o_dout         <= '0;
      o_frame_err    <= 1'b0;
    end else begin
      state          <= state_nx;
      s              <= s_nx;
      n              <= n_nx;
      b              <= b_nx;
      o_rx_done_tick <= done_nx;
      // Result registers update only on the completing edge and hold otherwise.
      if (done_nx) begin
        o_dout      <= b;
        o_frame_err <= ~rx_s;
      end
    end
  end

  always_comb begin
    state_nx = state;
    s_nx     = s;
    n_nx     = n;
    b_nx     = b;
    done_nx  = 1'b0;

    unique case (state)
      IDLE: begin
        // The start edge is taken without waiting for a tick to keep alignment tight.
        if (!rx_s) begin
          state_nx = START;
          s_nx     = '0;
        end
      end

      START: begin
        if (i_s_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_nx = DATA;
              s_nx     = '0;
              n_nx     = '0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            s_nx = s + S_ONE;
          end
        end
      end

      DATA: begin
        if (i_s_tick) begin
          if (s == S_LAST) begin
            s_nx = '0;
            b_nx = {rx_s, b[DBIT-1:1]};
            if (n == N_LAST) begin
              state_nx = STOP;
            end else begin
              n_nx = n + N_ONE;
            end
          end else begin
            s_nx = s + S_ONE;
          end
        end
      end

      STOP: begin
        if (i_s_tick) begin
          if (s == S_STOP) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            s_nx = s + S_ONE;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames with a sample tick every 4 clocks (64 clocks per bit).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       s_tick;
  logic       done;
  logic [7:0] dout;
  logic       ferr;
  logic       busy;

  int         compared   = 0;
  int         mismatched = 0;
  int         done_cnt   = 0;
  int         base;
  logic [7:0] rec [0:31];
  bit         tick_en = 1'b1;

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_rx           (rx),
    .i_s_tick       (s_tick),
    .o_rx_done_tick (done),
    .o_dout         (dout),
    .o_frame_err    (ferr),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c      = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      s_tick = (tick_en && c == 3);
      c      = (c + 1) % 4;
    end
  end

  // Each high cycle of done is one pulse; the word is logged in arrival order.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (done_cnt < 32) rec[done_cnt] = dout;
      done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int k);
    repeat (k) @(negedge clk);
  endtask

  // A zero stop bit is cut short so the line is high again before the receiver re-checks it.
  task automatic send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(64);
    end
    rx = stop;
    wait_clks(stop ? 64 : 40);
    rx = 1'b1;
    if (!stop) wait_clks(24);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(3);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'h00);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_clks(20);

    base = done_cnt;
    send(8'h55, 1'b1);
    wait_clks(100);
    check("f55_pulses", done_cnt - base, 32'd1);
    check("f55_dout", {24'd0, dout}, 32'h55);
    check("f55_ferr", {31'd0, ferr}, 32'd0);
    check("f55_busy", {31'd0, busy}, 32'd0);

    base = done_cnt;
    rx   = 1'b0;
    wait_clks(16);
    check("glitch_busy_in", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    wait_clks(100);
    check("glitch_pulses", done_cnt - base, 32'd0);
    check("glitch_dout", {24'd0, dout}, 32'h55);
    check("glitch_busy_out", {31'd0, busy}, 32'd0);

    base = done_cnt;
    send(8'hA3, 1'b0);
    wait_clks(100);
    check("fa3_pulses", done_cnt - base, 32'd1);
    check("fa3_dout", {24'd0, dout}, 32'hA3);
    check("fa3_ferr", {31'd0, ferr}, 32'd1);

    base = done_cnt;
    send(8'h01, 1'b1);
    wait_clks(100);
    check("f01_pulses", done_cnt - base, 32'd1);
    check("f01_dout", {24'd0, dout}, 32'h01);
    check("f01_ferr", {31'd0, ferr}, 32'd0);

    // 0xF0 aborted partway into its fourth data bit; the line is released with the reset.
    base = done_cnt;
    rx   = 1'b0;
    wait_clks(64 + 3 * 64 + 20);
    check("midrst_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(1);
    check("midrst_dout", {24'd0, dout}, 32'h00);
    check("midrst_ferr", {31'd0, ferr}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    wait_clks(1);
    reset = 1'b0;
    wait_clks(200);
    check("postrst_pulses", done_cnt - base, 32'd0);
    check("postrst_dout", {24'd0, dout}, 32'h00);
    check("postrst_busy", {31'd0, busy}, 32'd0);

    base = done_cnt;
    send(8'h3C, 1'b1);
    wait_clks(100);
    check("f3c_pulses", done_cnt - base, 32'd1);
    check("f3c_dout", {24'd0, dout}, 32'h3C);
    check("f3c_ferr", {31'd0, ferr}, 32'd0);

    base = done_cnt;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    wait_clks(100);
    check("b2b_pulses", done_cnt - base, 32'd2);
    check("b2b_first", {24'd0, rec[base % 32]}, 32'h00);
    check("b2b_second", {24'd0, rec[(base + 1) % 32]}, 32'hFF);
    check("b2b_ferr", {31'd0, ferr}, 32'd0);

    tick_en = 1'b0;
    wait_clks(2);
    base = done_cnt;
    rx   = 1'b0;
    wait_clks(1000);
    check("notick_busy", {31'd0, busy}, 32'd1);
    check("notick_s", {28'd0, dut.s}, 32'd0);
    check("notick_pulses", done_cnt - base, 32'd0);
    rx      = 1'b1;
    tick_en = 1'b1;
    wait_clks(100);
    check("notick_release_busy", {31'd0, busy}, 32'd0);
    check("notick_release_pulses", done_cnt - base, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
